matmul_result_writeback: RTL

- Downstream stage of the 4x4 block matmul engine.
- Accepts one completed 4x4 int32 accumulator block plus output addressing.
- Per element: bias add, fixed-point requantize, round, optional ReLU, zero-point add, saturate to int8.
- Writes one packed 32-bit word per valid row to memory through a req/ack write port; frees the engine to start the next block while writeback proceeds.

---
 rtl/matmul_pkg.sv | 37 +++
 rtl/matmul_result_writeback_requant_lane.sv | 69 ++++++
 rtl/matmul_result_writeback.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the 4x4 block matmul result path.
// Block geometry constants, FSM state encoding, in_data packing index.
// Pure declarations; no logic of its own.
package matmul_pkg;

  localparam int BLK   = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUANT = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // LSB of element c[i][j] inside the flattened accumulator block.
  function automatic int acc_lsb(input int i, input int j);
    return (i * BLK + j) * ACC_W;
  endfunction

  // Row/column counts above the block size mean "the whole block".
  function automatic logic [2:0] clamp_dim(input logic [2:0] d);
    return (d > 3'd4) ? 3'd4 : d;
  endfunction

  // Byte enables for the first n lanes of a packed row word.
  function automatic logic [BLK-1:0] we_mask(input logic [2:0] n);
    logic [BLK:0] t;
    logic [BLK:0] u;
    t    = '0;
    t[n] = 1'b1;
    u    = t - 1'b1;
    return u[BLK-1:0];
  endfunction

endpackage

// File: rtl/matmul_result_writeback_requant_lane.sv
// One output lane: bias add, requantize, round, ReLU, zero point, int8 saturate.
// Purely combinational, zero cycles.
// No handshake; the parent holds all operands stable while the result is used.
module requant_lane
  import matmul_pkg::*;
#(
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic signed [MULT_W-1:0]  mult,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic signed [OUT_W-1:0]   zp,
  input  logic                      relu,
  output logic signed [OUT_W-1:0]   q
);

  // Product width plus one guard bit for the rounding add, plus one for zp.
  localparam int P_W = ACC_W + MULT_W;
  localparam int R_W = P_W + 1;
  localparam int Z_W = R_W + 1;

  localparam logic signed [Z_W-1:0] Q_MIN = Z_W'(-128);
  localparam logic signed [Z_W-1:0] Q_MAX = Z_W'(127);

  logic signed [ACC_W:0]   sum_w;
  logic signed [ACC_W-1:0] sat_s;
  logic signed [P_W-1:0]   prod;
  logic signed [R_W-1:0]   prod_x;
  logic signed [R_W-1:0]   half;
  logic signed [R_W-1:0]   r_w;
  logic signed [Z_W-1:0]   z_w;

  // Full lane arithmetic; each stage is sized so no intermediate can wrap.
  always_comb begin
    sum_w = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      sat_s = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_s = sum_w[ACC_W-1:0];
    end

    prod   = $signed({{MULT_W{sat_s[ACC_W-1]}}, sat_s}) *
             $signed({{ACC_W{mult[MULT_W-1]}}, mult});
    prod_x = {prod[P_W-1], prod};

    half = '0;
    r_w  = prod_x;
    if (shift != '0) begin
      half = R_W'(1) << (shift - 1'b1);
      r_w  = (prod_x + half) >>> shift;
    end

    if (relu && r_w[R_W-1]) begin
      r_w = '0;
    end

    z_w = {r_w[R_W-1], r_w} + {{(Z_W-OUT_W){zp[OUT_W-1]}}, zp};
    if (z_w < Q_MIN) begin
      q = 8'sh80;
    end else if (z_w > Q_MAX) begin
      q = 8'sh7F;
    end else begin
      q = z_w[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/matmul_result_writeback.sv
// Requantizes a 4x4 int32 block to int8 and writes one packed word per valid row.
// Accept at T: first mem_req at T+2, 2 cycles per row with ack high, done at T+2m+1.
// in_ready only in idle; mem_req holds address/data/enables stable until mem_ack.
module matmul_result_writeback
  import matmul_pkg::*;
#(
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BLK*BLK*ACC_W-1:0]   in_data,
  input  logic [2:0]                 in_m,
  input  logic [2:0]                 in_n,
  input  logic [31:0]                in_out_addr,
  input  logic [31:0]                in_row_stride,
  input  logic [BLK*ACC_W-1:0]       cfg_bias,
  input  logic signed [MULT_W-1:0]   cfg_mult,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  input  logic signed [OUT_W-1:0]    cfg_zp,
  input  logic                       cfg_relu,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_we,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic                       done
);

  state_e state_q, state_d;

  // Block registers, captured on accept so later cfg changes cannot leak in.
  logic [BLK*BLK*ACC_W-1:0] data_q,     data_d;
  logic [2:0]               m_q,        m_d;
  logic [2:0]               n_q,        n_d;
  logic [1:0]               row_q,      row_d;
  logic [31:0]              row_addr_q, row_addr_d;
  logic [31:0]              stride_q,   stride_d;
  logic [BLK*ACC_W-1:0]     bias_q,     bias_d;
  logic signed [MULT_W-1:0] mult_q,     mult_d;
  logic [SHIFT_W-1:0]       shift_q,    shift_d;
  logic signed [OUT_W-1:0]  zp_q,       zp_d;
  logic                     relu_q,     relu_d;

  // Write port registers.
  logic [31:0]              waddr_q,    waddr_d;
  logic [31:0]              wdata_q,    wdata_d;
  logic [3:0]               we_q,       we_d;

  logic signed [ACC_W-1:0]  lane_acc [BLK];
  logic signed [OUT_W-1:0]  lane_out [BLK];
  logic [BLK*OUT_W-1:0]     row_word;
  logic [2:0]               m_in;
  logic [2:0]               n_in;
  logic                     last_row;

  assign m_in     = clamp_dim(in_m);
  assign n_in     = clamp_dim(in_n);
  assign last_row = ({1'b0, row_q} + 3'd1) >= m_q;

  for (genvar j = 0; j < BLK; j++) begin : g_lane
    requant_lane #(
      .MULT_W  (MULT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .acc   (lane_acc[j]),
      .bias  (bias_q[j*ACC_W +: ACC_W]),
      .mult  (mult_q),
      .shift (shift_q),
      .zp    (zp_q),
      .relu  (relu_q),
      .q     (lane_out[j])
    );
  end

  // Select the current row for the four lanes and pack it, zeroing unused columns.
  always_comb begin
    for (int j = 0; j < BLK; j++) begin
      lane_acc[j] = data_q[acc_lsb(int'(row_q), j) +: ACC_W];
      row_word[j*OUT_W +: OUT_W] = (j < int'(n_q)) ? lane_out[j] : '0;
    end
  end

  // Next-state and next-register logic for the row sequencer.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    m_d        = m_q;
    n_d        = n_q;
    row_d      = row_q;
    row_addr_d = row_addr_q;
    stride_d   = stride_q;
    bias_d     = bias_q;
    mult_d     = mult_q;
    shift_d    = shift_q;
    zp_d       = zp_q;
    relu_d     = relu_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          m_d        = m_in;
          n_d        = n_in;
          row_d      = '0;
          row_addr_d = in_out_addr;
          stride_d   = in_row_stride;
          bias_d     = cfg_bias;
          mult_d     = cfg_mult;
          shift_d    = cfg_shift;
          zp_d       = cfg_zp;
          relu_d     = cfg_relu;
          // An empty block still completes, just without touching memory.
          state_d    = (m_in == 3'd0 || n_in == 3'd0) ? S_DONE : S_QUANT;
        end
      end
      S_QUANT: begin
        waddr_d = row_addr_q;
        wdata_d = row_word;
        we_d    = we_mask(n_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ack) begin
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d      = row_q + 2'd1;
            row_addr_d = row_addr_q + stride_q;
            state_d    = S_QUANT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and write-port registers; reset abandons any write in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Block payload registers; only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    data_q     <= data_d;
    m_q        <= m_d;
    n_q        <= n_d;
    row_addr_q <= row_addr_d;
    stride_q   <= stride_d;
    bias_q     <= bias_d;
    mult_q     <= mult_d;
    shift_q    <= shift_d;
    zp_q       <= zp_d;
    relu_q     <= relu_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

endmodule
